pe_config_loader: RTL and testbench

Configuration writer for one PE tile: receives a chunked configuration frame over a valid/ready stream and assembles it in a shadow register. After a well-formed frame it commits atomically to the ConfigBits/ConfigBits_N pair that drives the PE switch matrix select inputs. Malformed frames are rejected, and the active configuration is left untouched.

---
 rtl/pe_cfg_pkg.sv | 19 +
 rtl/pe_config_loader.sv | 113 +++++++++++
 tb/tb_pe_config_loader.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_cfg_pkg.sv
// Shared types and helpers for the PE tile configuration loader.
package pe_cfg_pkg;

    // Loader control states
    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        DRAIN  = 2'd1,
        COMMIT = 2'd2
    } cfg_state_t;

    // Default stream chunk width
    localparam int unsigned CFG_CHUNK_W = 8;

    // Ceiling division: chunks needed to carry a configuration word
    function automatic int unsigned num_chunks(input int unsigned bits, input int unsigned chunk_w);
        return (bits + chunk_w - 1) / chunk_w;
    endfunction

endpackage

// File: rtl/pe_config_loader.sv
// PE tile configuration loader: assembles a chunked frame from a valid/ready
// stream into a shadow register and commits it atomically to the
// ConfigBits/ConfigBits_N pair driving the switch matrix selects.
module pe_config_loader
    import pe_cfg_pkg::*;
#(
    parameter int unsigned NoConfigBits = 28,
    parameter int unsigned CHUNK_W      = CFG_CHUNK_W
) (
    input  logic                    CLK,
    input  logic                    RESETn,
    input  logic [CHUNK_W-1:0]      cfg_data,
    input  logic                    cfg_valid,
    input  logic                    cfg_last,
    output logic                    cfg_ready,
    input  logic                    clr_err,
    output logic [NoConfigBits-1:0] ConfigBits,
    output logic [NoConfigBits-1:0] ConfigBits_N,
    output logic                    cfg_done,
    output logic                    cfg_err,
    output logic                    cfg_err_sticky
);

    localparam int unsigned NUM_CHUNKS = num_chunks(NoConfigBits, CHUNK_W);
    localparam int unsigned SHADOW_W   = NUM_CHUNKS * CHUNK_W;
    localparam int unsigned IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    cfg_state_t              state;
    logic [IDX_W-1:0]        idx;
    logic [NoConfigBits-1:0] shadow;
    logic [NoConfigBits-1:0] chunk_mask;
    logic [NoConfigBits-1:0] chunk_bits;
    logic                    xfer;
    logic                    err_event;

    // Place the incoming chunk at its slot. The shadow holds only the bits that
    // can reach ConfigBits; pad bits of the last chunk fall off in the truncating cast.
    always_comb begin
        chunk_mask = NoConfigBits'({SHADOW_W{1'b0}} | (SHADOW_W'({CHUNK_W{1'b1}}) << (idx * CHUNK_W)));
        chunk_bits = NoConfigBits'(SHADOW_W'(cfg_data) << (idx * CHUNK_W));
    end

    // Handshake qualification and frame-length error detection
    always_comb begin
        xfer      = cfg_valid & cfg_ready;
        err_event = 1'b0;
        if (xfer && state == LOAD) begin
            err_event = (idx != LAST_IDX) ? cfg_last : ~cfg_last;
        end
    end

    // Loader FSM with registered outputs and sticky error tracking
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state          <= LOAD;
            idx            <= '0;
            shadow         <= '0;
            ConfigBits     <= '0;
            ConfigBits_N   <= '1;
            cfg_done       <= 1'b0;
            cfg_err        <= 1'b0;
            cfg_err_sticky <= 1'b0;
            cfg_ready      <= 1'b1;
        end else begin
            cfg_done <= 1'b0;
            cfg_err  <= err_event;

            if (err_event) begin
                cfg_err_sticky <= 1'b1;
            end else if (clr_err) begin
                cfg_err_sticky <= 1'b0;
            end

            case (state)
                LOAD: begin
                    if (xfer) begin
                        shadow <= (shadow & ~chunk_mask) | chunk_bits;
                        if (idx != LAST_IDX) begin
                            idx <= cfg_last ? '0 : idx + 1'b1;
                        end else begin
                            idx <= '0;
                            if (cfg_last) begin
                                state     <= COMMIT;
                                cfg_ready <= 1'b0;
                            end else begin
                                state <= DRAIN;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (xfer && cfg_last) begin
                        state <= LOAD;
                    end
                end
                COMMIT: begin
                    ConfigBits   <= shadow;
                    ConfigBits_N <= ~shadow;
                    cfg_done     <= 1'b1;
                    state        <= LOAD;
                    cfg_ready    <= 1'b1;
                end
                default: begin
                    state     <= LOAD;
                    idx       <= '0;
                    cfg_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pe_config_loader.sv
// Directed self-checking bench for pe_config_loader.
module tb_pe_config_loader;

    localparam int NB = 28;
    localparam int CW = 8;

    logic          CLK = 1'b0;
    logic          RESETn = 1'b0;
    logic [CW-1:0] cfg_data = '0;
    logic          cfg_valid = 1'b0;
    logic          cfg_last = 1'b0;
    logic          clr_err = 1'b0;
    logic          cfg_ready;
    logic [NB-1:0] ConfigBits;
    logic [NB-1:0] ConfigBits_N;
    logic          cfg_done;
    logic          cfg_err;
    logic          cfg_err_sticky;

    int tests_run = 0;
    int tests_failed = 0;

    pe_config_loader #(.NoConfigBits(NB), .CHUNK_W(CW)) dut (
        .CLK(CLK),
        .RESETn(RESETn),
        .cfg_data(cfg_data),
        .cfg_valid(cfg_valid),
        .cfg_last(cfg_last),
        .cfg_ready(cfg_ready),
        .clr_err(clr_err),
        .ConfigBits(ConfigBits),
        .ConfigBits_N(ConfigBits_N),
        .cfg_done(cfg_done),
        .cfg_err(cfg_err),
        .cfg_err_sticky(cfg_err_sticky)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Offer one chunk and return just after the edge that accepts it; valid stays high
    task automatic send_chunk(input logic [CW-1:0] d, input logic last);
        int n = 0;
        cfg_data  = d;
        cfg_last  = last;
        cfg_valid = 1'b1;
        while (!cfg_ready && n < 16) begin
            tick();
            n++;
        end
        if (!cfg_ready) begin
            tests_run++;
            tests_failed++;
            $display("FAIL ready_timeout: cfg_ready=%b required 1", cfg_ready);
        end
        tick();
    endtask

    task automatic idle();
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
    endtask

    task automatic test_reset();
        RESETn = 1'b0;
        tick();
        tick();
        RESETn = 1'b1;
        tick();
        tests_run++; if (ConfigBits !== 28'h0) begin tests_failed++; $display("FAIL reset_cfg: got %h required %h", ConfigBits, 28'h0); end
        tests_run++; if (ConfigBits_N !== 28'hFFFFFFF) begin tests_failed++; $display("FAIL reset_cfg_n: got %h required %h", ConfigBits_N, 28'hFFFFFFF); end
        tests_run++; if (cfg_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b required 1", cfg_ready); end
        tests_run++; if ({cfg_done, cfg_err, cfg_err_sticky} !== 3'b000) begin tests_failed++; $display("FAIL reset_flags: got %b required 000", {cfg_done, cfg_err, cfg_err_sticky}); end
    endtask

    task automatic test_good_frame();
        send_chunk(8'h78, 1'b0);
        send_chunk(8'h56, 1'b0);
        send_chunk(8'h34, 1'b0);
        send_chunk(8'h12, 1'b1);
        idle();
        tests_run++; if (cfg_ready !== 1'b0) begin tests_failed++; $display("FAIL good_commit_ready: got %b required 0", cfg_ready); end
        tests_run++; if (cfg_done !== 1'b0) begin tests_failed++; $display("FAIL good_done_early: got %b required 0", cfg_done); end
        tests_run++; if (ConfigBits !== 28'h0) begin tests_failed++; $display("FAIL good_cfg_early: got %h required %h", ConfigBits, 28'h0); end
        tick();
        tests_run++; if (ConfigBits !== 28'h2345678) begin tests_failed++; $display("FAIL good_cfg: got %h required %h", ConfigBits, 28'h2345678); end
        tests_run++; if (ConfigBits_N !== 28'hDCBA987) begin tests_failed++; $display("FAIL good_cfg_n: got %h required %h", ConfigBits_N, 28'hDCBA987); end
        tests_run++; if (cfg_done !== 1'b1) begin tests_failed++; $display("FAIL good_done: got %b required 1", cfg_done); end
        tests_run++; if (cfg_err !== 1'b0) begin tests_failed++; $display("FAIL good_err: got %b required 0", cfg_err); end
        tests_run++; if (cfg_ready !== 1'b1) begin tests_failed++; $display("FAIL good_ready_back: got %b required 1", cfg_ready); end
        tick();
        tests_run++; if (cfg_done !== 1'b0) begin tests_failed++; $display("FAIL good_done_pulse: got %b required 0", cfg_done); end
    endtask

    task automatic test_pad_bits();
        send_chunk(8'h78, 1'b0);
        send_chunk(8'h56, 1'b0);
        send_chunk(8'h34, 1'b0);
        send_chunk(8'hF2, 1'b1);
        idle();
        tick();
        tests_run++; if (ConfigBits !== 28'h2345678) begin tests_failed++; $display("FAIL pad_cfg: got %h required %h", ConfigBits, 28'h2345678); end
        tests_run++; if ((ConfigBits ^ ConfigBits_N) !== 28'hFFFFFFF) begin tests_failed++; $display("FAIL pad_xor: got %h required %h", ConfigBits ^ ConfigBits_N, 28'hFFFFFFF); end
        tests_run++; if (cfg_done !== 1'b1) begin tests_failed++; $display("FAIL pad_done: got %b required 1", cfg_done); end
        tick();
    endtask

    task automatic test_short_frame();
        send_chunk(8'hAA, 1'b0);
        send_chunk(8'hBB, 1'b1);
        idle();
        tests_run++; if (cfg_err !== 1'b1) begin tests_failed++; $display("FAIL short_err: got %b required 1", cfg_err); end
        tests_run++; if (cfg_err_sticky !== 1'b1) begin tests_failed++; $display("FAIL short_sticky: got %b required 1", cfg_err_sticky); end
        tests_run++; if (cfg_ready !== 1'b1) begin tests_failed++; $display("FAIL short_ready: got %b required 1", cfg_ready); end
        tick();
        tests_run++; if (cfg_err !== 1'b0) begin tests_failed++; $display("FAIL short_err_pulse: got %b required 0", cfg_err); end
        tests_run++; if (cfg_done !== 1'b0) begin tests_failed++; $display("FAIL short_no_done: got %b required 0", cfg_done); end
        tests_run++; if (ConfigBits !== 28'h2345678) begin tests_failed++; $display("FAIL short_cfg_kept: got %h required %h", ConfigBits, 28'h2345678); end
        send_chunk(8'h01, 1'b0);
        send_chunk(8'h00, 1'b0);
        send_chunk(8'h00, 1'b0);
        send_chunk(8'h00, 1'b1);
        idle();
        tick();
        tests_run++; if (ConfigBits !== 28'h0000001) begin tests_failed++; $display("FAIL short_next_cfg: got %h required %h", ConfigBits, 28'h0000001); end
        tests_run++; if (ConfigBits_N !== 28'hFFFFFFE) begin tests_failed++; $display("FAIL short_next_cfg_n: got %h required %h", ConfigBits_N, 28'hFFFFFFE); end
        tests_run++; if (cfg_done !== 1'b1) begin tests_failed++; $display("FAIL short_next_done: got %b required 1", cfg_done); end
        tick();
    endtask

    task automatic test_err_clear_race();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        tests_run++; if (cfg_err_sticky !== 1'b0) begin tests_failed++; $display("FAIL clr_sticky: got %b required 0", cfg_err_sticky); end
        send_chunk(8'hCC, 1'b0);
        clr_err = 1'b1;
        send_chunk(8'hDD, 1'b1);
        clr_err = 1'b0;
        idle();
        tests_run++; if (cfg_err_sticky !== 1'b1) begin tests_failed++; $display("FAIL race_sticky: got %b required 1", cfg_err_sticky); end
        tick();
        tests_run++; if (cfg_err_sticky !== 1'b1) begin tests_failed++; $display("FAIL race_sticky_hold: got %b required 1", cfg_err_sticky); end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        tests_run++; if (cfg_err_sticky !== 1'b0) begin tests_failed++; $display("FAIL race_clr: got %b required 0", cfg_err_sticky); end
    endtask

    task automatic test_long_frame();
        send_chunk(8'h11, 1'b0);
        send_chunk(8'h22, 1'b0);
        send_chunk(8'h33, 1'b0);
        tests_run++; if (cfg_err !== 1'b0) begin tests_failed++; $display("FAIL long_err_early: got %b required 0", cfg_err); end
        send_chunk(8'h44, 1'b0);
        tests_run++; if (cfg_err !== 1'b1) begin tests_failed++; $display("FAIL long_err: got %b required 1", cfg_err); end
        tests_run++; if (cfg_err_sticky !== 1'b1) begin tests_failed++; $display("FAIL long_sticky: got %b required 1", cfg_err_sticky); end
        send_chunk(8'h55, 1'b0);
        tests_run++; if (cfg_err !== 1'b0) begin tests_failed++; $display("FAIL long_err_pulse: got %b required 0", cfg_err); end
        tests_run++; if (cfg_ready !== 1'b1) begin tests_failed++; $display("FAIL long_drain_ready: got %b required 1", cfg_ready); end
        send_chunk(8'h66, 1'b1);
        idle();
        tests_run++; if ({cfg_done, cfg_err} !== 2'b00) begin tests_failed++; $display("FAIL long_end_flags: got %b required 00", {cfg_done, cfg_err}); end
        tick();
        tests_run++; if (cfg_done !== 1'b0) begin tests_failed++; $display("FAIL long_no_done: got %b required 0", cfg_done); end
        tests_run++; if (ConfigBits !== 28'h0000001) begin tests_failed++; $display("FAIL long_cfg_kept: got %h required %h", ConfigBits, 28'h0000001); end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        tests_run++; if (cfg_err_sticky !== 1'b0) begin tests_failed++; $display("FAIL long_clr: got %b required 0", cfg_err_sticky); end
    endtask

    task automatic test_back_to_back();
        send_chunk(8'h0D, 1'b0);
        send_chunk(8'hC0, 1'b0);
        send_chunk(8'hAD, 1'b0);
        send_chunk(8'h0B, 1'b1);
        cfg_data = 8'hEF;
        cfg_last = 1'b0;
        tests_run++; if (cfg_ready !== 1'b0) begin tests_failed++; $display("FAIL b2b_ready_low: got %b required 0", cfg_ready); end
        tick();
        tests_run++; if (cfg_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready_high: got %b required 1", cfg_ready); end
        tests_run++; if (cfg_done !== 1'b1) begin tests_failed++; $display("FAIL b2b_done_a: got %b required 1", cfg_done); end
        tests_run++; if (ConfigBits !== 28'hBADC00D) begin tests_failed++; $display("FAIL b2b_cfg_a: got %h required %h", ConfigBits, 28'hBADC00D); end
        tests_run++; if (ConfigBits_N !== 28'h4523FF2) begin tests_failed++; $display("FAIL b2b_cfg_n_a: got %h required %h", ConfigBits_N, 28'h4523FF2); end
        send_chunk(8'hEF, 1'b0);
        send_chunk(8'hBE, 1'b0);
        send_chunk(8'hAD, 1'b0);
        send_chunk(8'h0E, 1'b1);
        idle();
        tests_run++; if (cfg_ready !== 1'b0) begin tests_failed++; $display("FAIL b2b_ready_low_b: got %b required 0", cfg_ready); end
        tick();
        tests_run++; if (ConfigBits !== 28'hEADBEEF) begin tests_failed++; $display("FAIL b2b_cfg_b: got %h required %h", ConfigBits, 28'hEADBEEF); end
        tests_run++; if (ConfigBits_N !== 28'h1524110) begin tests_failed++; $display("FAIL b2b_cfg_n_b: got %h required %h", ConfigBits_N, 28'h1524110); end
        tests_run++; if (cfg_done !== 1'b1) begin tests_failed++; $display("FAIL b2b_done_b: got %b required 1", cfg_done); end
        tick();
    endtask

    task automatic test_reset_midframe();
        send_chunk(8'h12, 1'b0);
        send_chunk(8'h34, 1'b0);
        idle();
        RESETn = 1'b0;
        #1;
        tests_run++; if (ConfigBits !== 28'h0) begin tests_failed++; $display("FAIL rst_mid_cfg: got %h required %h", ConfigBits, 28'h0); end
        tests_run++; if (ConfigBits_N !== 28'hFFFFFFF) begin tests_failed++; $display("FAIL rst_mid_cfg_n: got %h required %h", ConfigBits_N, 28'hFFFFFFF); end
        tests_run++; if (cfg_done !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_done: got %b required 0", cfg_done); end
        tick();
        RESETn = 1'b1;
        tick();
        tests_run++; if (cfg_done !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_no_done: got %b required 0", cfg_done); end
        send_chunk(8'h44, 1'b0);
        send_chunk(8'h33, 1'b0);
        send_chunk(8'h22, 1'b0);
        send_chunk(8'h11, 1'b1);
        idle();
        tick();
        tests_run++; if (ConfigBits !== 28'h1223344) begin tests_failed++; $display("FAIL rst_next_cfg: got %h required %h", ConfigBits, 28'h1223344); end
        tests_run++; if (ConfigBits_N !== 28'hEDDCCBB) begin tests_failed++; $display("FAIL rst_next_cfg_n: got %h required %h", ConfigBits_N, 28'hEDDCCBB); end
        tests_run++; if ({cfg_done, cfg_err} !== 2'b10) begin tests_failed++; $display("FAIL rst_next_flags: got %b required 10", {cfg_done, cfg_err}); end
        tick();
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_pad_bits();
        test_short_frame();
        test_err_clear_race();
        test_long_frame();
        test_back_to_back();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
